// File: rtl/wishbone_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master_bridge_pkg
// Description : Shared encodings for the memory controller's Wishbone bridge:
//               FSM state codes, the error read pattern, the WB region nibble
//               and the latched request record.
// Revision    : 1.0 - initial release
// ============================================================================
package wishbone_master_bridge_pkg;

  // Bridge FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Read data returned for failed cycles; the memory controller also returns
  // it for unselected sources, so the value must stay in sync with it.
  localparam logic [31:0] ERR_READ_PATTERN = 32'hFFFF_FFFF;

  // Top address nibble that routes a controller request to this bridge
  localparam logic [3:0] WB_REGION_NIBBLE = 4'b0001;

  localparam int unsigned WB_ADDR_WIDTH = 28;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = 4;

  // One request as presented on the Wishbone outputs for a whole bus cycle
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic                     we;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Data handed back on a successful ack: writes return zero, reads the bus
  function automatic logic [WB_DATA_WIDTH-1:0] wb_read_result(
    input logic                     we,
    input logic [WB_DATA_WIDTH-1:0] bus_data
  );
    return we ? '0 : bus_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_master_bridge_wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Counts cycles spent waiting for a Wishbone response and flags
//               when the last permitted cycle has been reached.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter
  import wishbone_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The count seen in the final permitted wait cycle; the counter value is
  // the index of the current bus cycle (0 in the first one).
  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count_q;
  logic [TIMEOUT_WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise advance and saturate at the last value
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/wishbone_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master_bridge
// Description : Responder for the memory controller's enable/busy request
//               port and initiator of Wishbone classic single cycles. Each
//               request becomes one bus cycle, bounded by an ack timeout, and
//               completes with a one-cycle not-busy pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master_bridge
  import wishbone_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  // Memory controller request port
  input  logic [27:0] wbAddress,
  input  logic [3:0]  wbByteSelect,
  input  logic        wbEnable,
  input  logic        wbWriteEnable,
  input  logic [31:0] wbDataWrite,
  output logic [31:0] wbDataRead,
  output logic        wbBusy,
  output logic        wbError,
  // Wishbone classic master
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [27:0] wb_adr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic [1:0]  state_q, state_d;
  wb_req_t     req_q, req_d;
  logic        cyc_q, cyc_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_expired;
  logic        bus_fail;

  // The counter sits at zero while idle so the first bus cycle sees count 0
  assign tmo_clear  = (state_q == ST_IDLE);
  assign tmo_enable = (state_q == ST_BUS);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  // err beats ack; a timeout only counts when the slave gave no answer
  assign bus_fail = wb_err_i || (!wb_ack_i && tmo_expired);

  // Next-state and next-output logic; every output is a register
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b1;
        cyc_d  = 1'b0;
        if (wbEnable) begin
          req_d = '{adr:  wbAddress,
                    sel:  wbByteSelect,
                    we:   wbWriteEnable,
                    data: wbDataWrite};
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Request fields stay frozen in req_q for the whole cycle
        if (bus_fail) begin
          rdata_d = ERR_READ_PATTERN;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          state_d = ST_DONE;
        end else if (wb_ack_i) begin
          rdata_d = wb_read_result(req_q.we, wb_data_i);
          err_d   = 1'b0;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Completion lasts exactly one cycle; enable is not sampled here,
        // which guarantees an idle cycle between bus cycles.
        busy_d  = 1'b1;
        err_d   = 1'b0;
        rdata_d = ERR_READ_PATTERN;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b1;
        err_d   = 1'b0;
        cyc_d   = 1'b0;
        rdata_d = ERR_READ_PATTERN;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= ERR_READ_PATTERN;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = req_q.we;
  assign wb_sel_o   = req_q.sel;
  assign wb_adr_o   = req_q.adr;
  assign wb_data_o  = req_q.data;

  assign wbBusy     = busy_q;
  assign wbError    = err_q;
  assign wbDataRead = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wishbone_master_bridge
// Description : Self-checking bench for wishbone_master_bridge with a random
//               Wishbone slave and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_master_bridge;

  localparam int          T      = 8;
  localparam logic [31:0] ERRPAT = 32'hFFFF_FFFF;

  // slave response kinds
  localparam int RSP_ACK  = 0;
  localparam int RSP_ERR  = 1;
  localparam int RSP_BOTH = 2;
  localparam int RSP_NONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] wbAddress;
  logic [3:0]  wbByteSelect;
  logic        wbEnable;
  logic        wbWriteEnable;
  logic [31:0] wbDataWrite;
  logic [31:0] wbDataRead;
  logic        wbBusy;
  logic        wbError;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [27:0] wb_adr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks   = 0;
  int failures = 0;

  wishbone_master_bridge #(
    .TIMEOUT_CYCLES (T),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wbAddress     (wbAddress),
    .wbByteSelect  (wbByteSelect),
    .wbEnable      (wbEnable),
    .wbWriteEnable (wbWriteEnable),
    .wbDataWrite   (wbDataWrite),
    .wbDataRead    (wbDataRead),
    .wbBusy        (wbBusy),
    .wbError       (wbError),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_adr_o      (wb_adr_o),
    .wb_data_o     (wb_data_o),
    .wb_data_i     (wb_data_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Enable low for n cycles; stray ack/err must not start anything
  task automatic idle_cycles(input int n);
    wbEnable = 1'b0;
    for (int i = 0; i < n; i++) begin
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_err_i = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check_eq("idle_cyc",  32'(wb_cyc_o), 32'd0);
      check_eq("idle_busy", 32'(wbBusy),   32'd1);
      check_eq("idle_err",  32'(wbError),  32'd0);
      check_eq("idle_rd",   wbDataRead,    ERRPAT);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  // One request from IDLE (called at a negedge) through DONE and the
  // following idle cycle. Expectations come from the transaction rules:
  // the slave answers in bus cycle 'waits' unless the timeout (cycle T-1)
  // comes first; ack wins over timeout in the same cycle.
  task automatic run_txn(input logic [27:0] adr, input logic [3:0] sel, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input int resp, input bit keep_en, input int drop_at);
    bit          timed;
    bit          exp_err;
    int          k_end;
    logic [31:0] exp_rd;
    int          k;
    bit          done;

    timed   = (resp == RSP_NONE) || (waits >= T);
    k_end   = timed ? T - 1 : waits;
    exp_err = timed || (resp != RSP_ACK);
    exp_rd  = exp_err ? ERRPAT : (we ? 32'h0 : rdata);

    wbEnable      = 1'b1;
    wbAddress     = adr;
    wbByteSelect  = sel;
    wbWriteEnable = we;
    wbDataWrite   = wdata;
    wb_ack_i      = 1'b0;
    wb_err_i      = 1'b0;
    @(posedge clk); @(negedge clk);

    k    = 0;
    done = 1'b0;
    while (!done && k < 64) begin
      check_eq("bus_cyc",  32'(wb_cyc_o),  32'd1);
      check_eq("bus_stb",  32'(wb_stb_o),  32'd1);
      check_eq("bus_adr",  32'(wb_adr_o),  32'(adr));
      check_eq("bus_sel",  32'(wb_sel_o),  32'(sel));
      check_eq("bus_we",   32'(wb_we_o),   32'(we));
      check_eq("bus_dat",  wb_data_o,      wdata);
      check_eq("bus_busy", 32'(wbBusy),    32'd1);
      if (k == waits && resp != RSP_NONE) begin
        wb_ack_i  = (resp != RSP_ERR);
        wb_err_i  = (resp != RSP_ACK);
        wb_data_i = rdata;
      end else begin
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = $urandom;
      end
      if (k == drop_at) wbEnable = 1'b0;
      // request inputs are ignored outside IDLE
      wbAddress     = 28'($urandom);
      wbByteSelect  = 4'($urandom);
      wbWriteEnable = 1'($urandom_range(0, 1));
      wbDataWrite   = $urandom;
      @(posedge clk); @(negedge clk);
      if (!wbBusy) done = 1'b1;
      else k++;
    end
    check_eq("complete", 32'(done), 32'd1);
    check_eq("cycles",   32'(k),    32'(k_end));
    check_eq("done_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("done_stb", 32'(wb_stb_o), 32'd0);
    check_eq("done_err", 32'(wbError),  32'(exp_err));
    check_eq("done_rd",  wbDataRead,    exp_rd);

    // stray responses during DONE are ignored
    wb_ack_i = 1'($urandom_range(0, 1));
    wb_err_i = 1'($urandom_range(0, 1));
    wbEnable = keep_en;
    @(posedge clk); @(negedge clk);
    check_eq("post_busy", 32'(wbBusy),   32'd1);
    check_eq("post_cyc",  32'(wb_cyc_o), 32'd0);
    check_eq("post_err",  32'(wbError),  32'd0);
    check_eq("post_rd",   wbDataRead,    ERRPAT);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  initial begin
    int r;
    int resp;
    int waits;
    bit keep;
    int drop;

    rst           = 1'b1;
    wbEnable      = 1'b0;
    wbAddress     = '0;
    wbByteSelect  = '0;
    wbWriteEnable = 1'b0;
    wbDataWrite   = '0;
    wb_data_i     = '0;
    wb_ack_i      = 1'b0;
    wb_err_i      = 1'b0;

    #2;
    check_eq("rst_busy", 32'(wbBusy),   32'd1);
    check_eq("rst_rd",   wbDataRead,    ERRPAT);
    check_eq("rst_err",  32'(wbError),  32'd0);
    check_eq("rst_cyc",  32'(wb_cyc_o), 32'd0);
    check_eq("rst_stb",  32'(wb_stb_o), 32'd0);
    check_eq("rst_we",   32'(wb_we_o),  32'd0);
    check_eq("rst_sel",  32'(wb_sel_o), 32'd0);
    check_eq("rst_adr",  32'(wb_adr_o), 32'd0);
    check_eq("rst_dat",  wb_data_o,     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);

    // zero-wait read
    run_txn(28'h0000010, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 0, RSP_ACK, 1'b0, -1);
    // write with 3 wait states
    run_txn(28'h0000100, 4'b0011, 1'b1, 32'h12345678, 32'hCAFEF00D, 3, RSP_ACK, 1'b0, -1);
    // timeout, then a normal request
    run_txn(28'h0000200, 4'hF, 1'b0, 32'h0, 32'h0, 0, RSP_NONE, 1'b0, -1);
    run_txn(28'h0000204, 4'hF, 1'b0, 32'h0, 32'h55AA55AA, 1, RSP_ACK, 1'b0, -1);
    // ack arriving with the last permitted cycle still wins; one cycle later loses
    run_txn(28'h0000208, 4'hF, 1'b0, 32'h0, 32'h01234567, T - 1, RSP_ACK, 1'b0, -1);
    run_txn(28'h000020C, 4'hF, 1'b0, 32'h0, 32'h01234567, T, RSP_ACK, 1'b0, -1);
    // err together with ack
    run_txn(28'h0000300, 4'hF, 1'b0, 32'h0, 32'h11111111, 1, RSP_BOTH, 1'b0, -1);
    run_txn(28'h0000304, 4'h1, 1'b1, 32'hA5A5A5A5, 32'h0, 2, RSP_ERR, 1'b0, -1);
    // back-to-back reads with enable held high
    run_txn(28'h0000400, 4'hF, 1'b0, 32'h0, 32'h00000001, 0, RSP_ACK, 1'b1, -1);
    run_txn(28'h0000404, 4'hF, 1'b0, 32'h0, 32'h00000002, 1, RSP_ACK, 1'b0, -1);
    // abandoned request still completes, no further cycle follows
    run_txn(28'h0000500, 4'hF, 1'b0, 32'h0, 32'h77777777, 4, RSP_ACK, 1'b0, 1);
    idle_cycles(3);

    // reset in the middle of a bus cycle
    wbEnable      = 1'b1;
    wbAddress     = 28'h0000600;
    wbByteSelect  = 4'hF;
    wbWriteEnable = 1'b1;
    wbDataWrite   = 32'h87654321;
    @(posedge clk); @(negedge clk);
    check_eq("mid_cyc_pre", 32'(wb_cyc_o), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_cyc",  32'(wb_cyc_o), 32'd0);
    check_eq("mid_stb",  32'(wb_stb_o), 32'd0);
    check_eq("mid_busy", 32'(wbBusy),   32'd1);
    check_eq("mid_rd",   wbDataRead,    ERRPAT);
    check_eq("mid_adr",  32'(wb_adr_o), 32'd0);
    wbEnable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1);
    run_txn(28'h0000604, 4'hC, 1'b0, 32'h0, 32'h0BADF00D, 2, RSP_ACK, 1'b0, -1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       resp = RSP_ACK;
      else if (r == 7) resp = RSP_ERR;
      else if (r == 8) resp = RSP_BOTH;
      else             resp = RSP_NONE;
      waits = $urandom_range(0, 10);
      keep  = ($urandom_range(0, 2) == 0);
      drop  = (!keep && $urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      run_txn(28'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom,
              waits, resp, keep, drop);
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
